// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator driven by a valid/ready
// command port, returning data, bus error or timeout on a response port.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] limit;

  assign limit     = 16'(TIMEOUT_CYCLES - 1);
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            wb_adr_o <= cmd_adr;
            wb_dat_o <= cmd_dat;
            wb_sel_o <= cmd_sel;
            wb_we_o  <= cmd_we;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            cnt      <= '0;
            state    <= BUS;
          end
        end
        BUS: begin
          // err beats ack, and either beats the timeout limit
          if (wb_err_i || wb_ack_i || cnt == limit) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= wb_err_i;
            rsp_timeout <= !wb_err_i && !wb_ack_i;
            rsp_dat     <= (!wb_err_i && wb_ack_i && !wb_we_o)
                           ? wb_dat_i : 32'h0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: a scripted Wishbone responder,
// expected responses queued at command time and checked at handshake.
module tb_wb_cmd_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err, rsp_timeout;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic [3:0]  wb_sel_o;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 silent (timeout)
  task automatic run_cmd(input logic        we,
                         input logic [31:0] adr,
                         input logic [31:0] dat,
                         input logic [3:0]  sel,
                         input int          waits,
                         input int          mode,
                         input logic [31:0] rdat,
                         input int          hold);
    exp_t        e;
    int          cyc_n;
    int          exp_cyc;
    logic [31:0] d0;
    logic        hit;
    e.dat = (mode == 0 && !we) ? rdat : 32'h0;
    e.err = (mode == 1 || mode == 2);
    e.to  = (mode == 3);
    exp_cyc = (mode == 3) ? TO : waits + 1;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wb_adr", wb_adr_o, adr);
    chk("wb_dat", wb_dat_o, dat);
    chk("wb_sel", 32'(wb_sel_o), 32'(sel));
    chk("wb_we", 32'(wb_we_o), 32'(we));
    chk("wb_stb", 32'(wb_stb_o), 32'd1);
    cyc_n = 0;
    wb_dat_i = rdat;
    for (int i = 0; i < 100 && !rsp_valid; i++) begin
      if (wb_cyc_o) cyc_n++;
      hit = (mode != 3) && (cyc_n == waits + 1);
      wb_ack_i = hit && (mode == 0 || mode == 2);
      wb_err_i = hit && (mode == 1 || mode == 2);
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'hA5A5_5A5A;
    chk("rsp_arrived", 32'(rsp_valid), 32'd1);
    chk("cyc_cycles", 32'(cyc_n), 32'(exp_cyc));
    chk("cyc_dropped", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    d0 = rsp_dat;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_adr = 32'hFFFF_0000;
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_dat", rsp_dat, d0);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_cyc", 32'(wb_cyc_o), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    if (rsp_valid && q.size() > 0) begin
      e = q.pop_front();
      chk("rsp_dat", rsp_dat, e.dat);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
    end else begin
      chk("rsp_pop", 32'(rsp_valid), 32'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;

    run_cmd(1'b0, 32'h1000, 32'h0, 4'hF, 2, 0, 32'hDEAD_BEEF, 0);
    run_cmd(1'b1, 32'h1000, 32'h1, 4'h3, 0, 0, 32'h1234_5678, 0);
    run_cmd(1'b0, 32'h2000, 32'h0, 4'hF, 0, 3, 32'h1111_1111, 0);
    run_cmd(1'b0, 32'h3000, 32'h0, 4'hF, 1, 2, 32'h2222_2222, 0);
    run_cmd(1'b1, 32'h3004, 32'h9, 4'h1, 0, 1, 32'h3333_3333, 0);
    run_cmd(1'b0, 32'h4001, 32'h0, 4'h2, TO - 1, 0, 32'hCAFE_F00D, 0);
    run_cmd(1'b0, 32'h5000, 32'h0, 4'hF, 1, 0, 32'h0BAD_F00D, 5);

    // stray ack/err while idle must not start anything
    @(negedge clk);
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    chk("idle_ack_ready", 32'(cmd_ready), 32'd1);
    chk("idle_ack_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ack_cyc", 32'(wb_cyc_o), 32'd0);

    // reset in the middle of a bus cycle
    cmd_valid = 1'b1;
    cmd_we = 1'b0; cmd_adr = 32'h6000; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_cyc", 32'(wb_cyc_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_cyc", 32'(wb_cyc_o), 32'd0);
    chk("async_stb", 32'(wb_stb_o), 32'd0);
    chk("async_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    run_cmd(1'b0, 32'h7000, 32'h0, 4'hF, 0, 0, 32'h7777_0001, 0);
    chk("q_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
